// File: rtl/controle_maquina_cafe.sv
// rtl/controle_maquina_cafe.sv - main sequencer of the coffee machine
//
// Purpose: runs OCIOSO -> ESCOLHA -> SENSORES -> PAGAMENTO -> PREPARO (+ ERRO),
// gates the choice/sensor/payment sub-blocks, times brew, error hold and
// user-inactivity timeouts with one shared saturating counter.
//
// Ports:
//   clock, reset       system clock; synchronous active-high reset
//   iniciar            start request
//   cancelar           user cancel
//   escolha_ok         valid drink chosen
//   sensores_ok        sensors good
//   sensores_falha     any sensor fault
//   pagamento_ok       sufficient credit
//   atividade          user keypress, restarts the inactivity timeout
//   Estado[2:0]        state code for the display mux
//   en_escolha, en_sensores, en_pagamento   sub-block enables (Moore)
//   liberar_cafe       dispense valve (Moore, PREPARO)
//   devolver           1-cycle registered refund pulse
//   erro               fault indicator (Moore, ERRO)
module controle_maquina_cafe #(
    parameter int TEMPO_PREPARO  = 200,
    parameter int TIMEOUT_CICLOS = 5000,
    parameter int TEMPO_ERRO     = 100
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       cancelar,
    input  logic       escolha_ok,
    input  logic       sensores_ok,
    input  logic       sensores_falha,
    input  logic       pagamento_ok,
    input  logic       atividade,
    output logic [2:0] Estado,
    output logic       en_escolha,
    output logic       en_sensores,
    output logic       en_pagamento,
    output logic       liberar_cafe,
    output logic       devolver,
    output logic       erro
);

    typedef enum logic [2:0] {
        OCIOSO    = 3'b000,
        ESCOLHA   = 3'b001,
        SENSORES  = 3'b010,
        PAGAMENTO = 3'b011,
        PREPARO   = 3'b100,
        ERRO      = 3'b101
    } estado_t;

    localparam int MAX_A = (TEMPO_PREPARO > TIMEOUT_CICLOS) ? TEMPO_PREPARO : TIMEOUT_CICLOS;
    localparam int MAX_P = (MAX_A > TEMPO_ERRO) ? MAX_A : TEMPO_ERRO;
    localparam int CW    = $clog2(MAX_P) + 1;

    // Terminal counts: a state lasting N cycles leaves when the counter shows N-1.
    localparam logic [CW-1:0] LIM_PREPARO = CW'(TEMPO_PREPARO - 1);
    localparam logic [CW-1:0] LIM_TIMEOUT = CW'(TIMEOUT_CICLOS - 1);
    localparam logic [CW-1:0] LIM_ERRO    = CW'(TEMPO_ERRO - 1);

    estado_t       state;
    estado_t       next_state;
    logic [CW-1:0] cnt;
    logic          cnt_clr;
    logic          timeout;
    logic          dev_next;

    // A keypress in the same cycle as the terminal count still rescues the user.
    assign timeout = (cnt == LIM_TIMEOUT) && !atividade;

    always_comb begin
        next_state = state;
        cnt_clr    = 1'b0;
        case (state)
            OCIOSO: begin
                if (iniciar) next_state = ESCOLHA;
            end
            ESCOLHA: begin
                cnt_clr = atividade;
                if (cancelar)        next_state = OCIOSO;
                else if (timeout)    next_state = OCIOSO;
                else if (escolha_ok) next_state = SENSORES;
            end
            SENSORES: begin
                if (cancelar)            next_state = OCIOSO;
                else if (sensores_falha) next_state = ERRO;
                else if (sensores_ok)    next_state = PAGAMENTO;
            end
            PAGAMENTO: begin
                cnt_clr = atividade;
                if (cancelar)          next_state = OCIOSO;
                else if (timeout)      next_state = OCIOSO;
                else if (pagamento_ok) next_state = PREPARO;
            end
            PREPARO: begin
                if (cnt == LIM_PREPARO) next_state = OCIOSO;
            end
            ERRO: begin
                if (cnt == LIM_ERRO) next_state = OCIOSO;
            end
            default: next_state = OCIOSO;
        endcase
    end

    // The only exits from PAGAMENTO to OCIOSO are cancel and timeout, both refund.
    assign dev_next = (state == PAGAMENTO) && (next_state == OCIOSO);

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= OCIOSO;
            cnt      <= '0;
            devolver <= 1'b0;
        end else begin
            state    <= next_state;
            devolver <= dev_next;
            if ((next_state != state) || cnt_clr) begin
                cnt <= '0;
            end else if (cnt != {CW{1'b1}}) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign Estado       = state;
    assign en_escolha   = (state == ESCOLHA);
    assign en_sensores  = (state == SENSORES);
    assign en_pagamento = (state == PAGAMENTO);
    assign liberar_cafe = (state == PREPARO);
    assign erro         = (state == ERRO);

endmodule

// File: tb/tb_controle_maquina_cafe.sv
// tb/tb_controle_maquina_cafe.sv - scoreboard testbench for controle_maquina_cafe
module tb_controle_maquina_cafe;

    logic       clock;
    logic       reset;
    logic       iniciar, cancelar, escolha_ok, sensores_ok, sensores_falha, pagamento_ok, atividade;
    logic [2:0] Estado;
    logic       en_escolha, en_sensores, en_pagamento, liberar_cafe, devolver, erro;

    controle_maquina_cafe #(
        .TEMPO_PREPARO (4),
        .TIMEOUT_CICLOS(8),
        .TEMPO_ERRO    (3)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .iniciar       (iniciar),
        .cancelar      (cancelar),
        .escolha_ok    (escolha_ok),
        .sensores_ok   (sensores_ok),
        .sensores_falha(sensores_falha),
        .pagamento_ok  (pagamento_ok),
        .atividade     (atividade),
        .Estado        (Estado),
        .en_escolha    (en_escolha),
        .en_sensores   (en_sensores),
        .en_pagamento  (en_pagamento),
        .liberar_cafe  (liberar_cafe),
        .devolver      (devolver),
        .erro          (erro)
    );

    localparam logic [6:0] I_NONE = 7'b0000000;
    localparam logic [6:0] I_INI  = 7'b1000000;
    localparam logic [6:0] I_CAN  = 7'b0100000;
    localparam logic [6:0] I_ESC  = 7'b0010000;
    localparam logic [6:0] I_SOK  = 7'b0001000;
    localparam logic [6:0] I_SF   = 7'b0000100;
    localparam logic [6:0] I_POK  = 7'b0000010;
    localparam logic [6:0] I_ATV  = 7'b0000001;

    typedef struct {
        int         cyc;
        logic [8:0] v;
        string      nm;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Expected output vector {Estado, en_escolha, en_sensores, en_pagamento, liberar_cafe, devolver, erro}
    function automatic logic [8:0] expv(input logic [2:0] st, input logic dev);
        return {st, st == 3'd1, st == 3'd2, st == 3'd3, st == 3'd4, dev, st == 3'd5};
    endfunction

    // Apply inputs for one cycle; expect the outputs seen after the next edge.
    task automatic step(input logic rst, input logic [6:0] in, input logic [2:0] st,
                        input logic dev, input string nm);
        exp_t e;
        @(posedge clock);
        #1;
        reset = rst;
        {iniciar, cancelar, escolha_ok, sensores_ok, sensores_falha, pagamento_ok, atividade} = in;
        e.cyc = cyc + 1;
        e.v   = expv(st, dev);
        e.nm  = nm;
        q.push_back(e);
    endtask

    task automatic hold(input int n, input logic [6:0] in, input logic [2:0] st, input string nm);
        for (int i = 0; i < n; i++) step(1'b0, in, st, 1'b0, nm);
    endtask

    // Monitor: compares the DUT outputs each cycle against the scoreboard entry due then.
    always @(negedge clock) begin
        logic [8:0] act;
        exp_t       e;
        act = {Estado, en_escolha, en_sensores, en_pagamento, liberar_cafe, devolver, erro};
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            checks++;
            if (e.cyc < cyc) begin
                errors++;
                $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.nm, e.cyc, cyc);
            end else if (act !== e.v) begin
                errors++;
                $display("FAIL %s @cyc %0d: got %b required %b", e.nm, cyc, act, e.v);
            end
        end
    end

    task automatic normal_flow(input logic [6:0] prep_in, input string nm);
        step(1'b0, I_INI, 3'd1, 1'b0, {nm, "_escolha"});
        step(1'b0, I_ESC, 3'd2, 1'b0, {nm, "_sensores"});
        step(1'b0, I_SOK, 3'd3, 1'b0, {nm, "_pagamento"});
        step(1'b0, I_POK, 3'd4, 1'b0, {nm, "_preparo"});
        hold(3, prep_in, 3'd4, {nm, "_preparo_hold"});
        step(1'b0, prep_in, 3'd0, 1'b0, {nm, "_preparo_end"});
        step(1'b0, I_NONE, 3'd0, 1'b0, {nm, "_idle_after"});
    endtask

    initial begin
        reset = 1'b1;
        {iniciar, cancelar, escolha_ok, sensores_ok, sensores_falha, pagamento_ok, atividade} = I_NONE;

        step(1'b1, I_NONE, 3'd0, 1'b0, "reset");
        step(1'b1, I_INI,  3'd0, 1'b0, "reset_hold_iniciar");
        step(1'b0, I_NONE, 3'd0, 1'b0, "idle");

        // 1 normal flow
        normal_flow(I_NONE, "t1");

        // 2 cancel in PAGAMENTO
        step(1'b0, I_INI, 3'd1, 1'b0, "t2_escolha");
        step(1'b0, I_ESC, 3'd2, 1'b0, "t2_sensores");
        step(1'b0, I_SOK, 3'd3, 1'b0, "t2_pagamento");
        step(1'b0, I_CAN, 3'd0, 1'b1, "t2_cancel_devolver");
        step(1'b0, I_NONE, 3'd0, 1'b0, "t2_devolver_drop");

        // 3 sensor fault with sensores_ok together; ERRO ignores inputs
        step(1'b0, I_INI, 3'd1, 1'b0, "t3_escolha");
        step(1'b0, I_ESC, 3'd2, 1'b0, "t3_sensores");
        step(1'b0, I_SOK | I_SF, 3'd5, 1'b0, "t3_erro");
        hold(2, I_INI | I_CAN, 3'd5, "t3_erro_hold");
        step(1'b0, I_NONE, 3'd0, 1'b0, "t3_erro_end");

        // 4 timeout in ESCOLHA, idle
        step(1'b0, I_INI, 3'd1, 1'b0, "t4_escolha");
        hold(7, I_NONE, 3'd1, "t4_wait");
        step(1'b0, I_NONE, 3'd0, 1'b0, "t4_timeout");
        // 4b atividade at cycle 5
        step(1'b0, I_INI, 3'd1, 1'b0, "t4b_escolha");
        hold(4, I_NONE, 3'd1, "t4b_wait");
        step(1'b0, I_ATV, 3'd1, 1'b0, "t4b_atividade");
        hold(7, I_NONE, 3'd1, "t4b_wait2");
        step(1'b0, I_NONE, 3'd0, 1'b0, "t4b_timeout");

        // timeout in PAGAMENTO refunds
        step(1'b0, I_INI, 3'd1, 1'b0, "tp_escolha");
        step(1'b0, I_ESC, 3'd2, 1'b0, "tp_sensores");
        step(1'b0, I_SOK, 3'd3, 1'b0, "tp_pagamento");
        hold(7, I_NONE, 3'd3, "tp_wait");
        step(1'b0, I_NONE, 3'd0, 1'b1, "tp_timeout_devolver");
        step(1'b0, I_NONE, 3'd0, 1'b0, "tp_devolver_drop");

        // 5 cancel beats escolha_ok
        step(1'b0, I_INI, 3'd1, 1'b0, "t5_escolha");
        step(1'b0, I_CAN | I_ESC, 3'd0, 1'b0, "t5_priority");

        // 6 reset in 2nd cycle of PREPARO, then fresh flow with cancel held in PREPARO
        step(1'b0, I_INI, 3'd1, 1'b0, "t6_escolha");
        step(1'b0, I_ESC, 3'd2, 1'b0, "t6_sensores");
        step(1'b0, I_SOK, 3'd3, 1'b0, "t6_pagamento");
        step(1'b0, I_POK, 3'd4, 1'b0, "t6_preparo");
        step(1'b0, I_NONE, 3'd4, 1'b0, "t6_preparo2");
        step(1'b1, I_NONE, 3'd0, 1'b0, "t6_reset");
        step(1'b0, I_NONE, 3'd0, 1'b0, "t6_after_reset");
        normal_flow(I_CAN | I_INI, "t6f");

        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clock);
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
